// File: rtl/risc_pkg.sv
// Shared RV32I load/store definitions: funct3 sizes, LSU error codes and FSM states.
package risc_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] LSU_OK       = 2'b00;
  localparam logic [1:0] LSU_MISALIGN = 2'b01;
  localparam logic [1:0] LSU_ILLEGAL  = 2'b10;
  localparam logic [1:0] LSU_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // Stores only exist as SB/SH/SW; loads add the unsigned LBU/LHU forms.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] offset);
    if (f3[1:0] == 2'b01) return offset[0];
    if (f3[1:0] == 2'b10) return offset != 2'b00;
    return 1'b0;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store lane replication and load extraction/extension.
module lsu_align
  import risc_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [1:0]           offset_i,
  input  logic [2:0]           funct3_i,
  input  logic [WORD_SIZE-1:0] store_data_i,
  input  logic [WORD_SIZE-1:0] rdata_i,
  output logic [3:0]           be_o,
  output logic [WORD_SIZE-1:0] wdata_o,
  output logic [WORD_SIZE-1:0] rdata_o
);

  logic [WORD_SIZE-1:0] shifted_rdata;

  always_comb begin
    shifted_rdata = rdata_i >> {offset_i, 3'b000};
    be_o          = 4'b1111;
    wdata_o       = store_data_i;
    rdata_o       = shifted_rdata;

    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << offset_i;
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase

    case (funct3_i)
      F3_B:    rdata_o = {{(WORD_SIZE-8){shifted_rdata[7]}}, shifted_rdata[7:0]};
      F3_H:    rdata_o = {{(WORD_SIZE-16){shifted_rdata[15]}}, shifted_rdata[15:0]};
      F3_BU:   rdata_o = {{(WORD_SIZE-8){1'b0}}, shifted_rdata[7:0]};
      F3_HU:   rdata_o = {{(WORD_SIZE-16){1'b0}}, shifted_rdata[15:0]};
      default: rdata_o = shifted_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: one load/store per request over a req/gnt/rvalid port, with
// alignment, illegal-size and bus-timeout error reporting.
module load_store_unit
  import risc_pkg::*;
#(
  parameter int WORD_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [WORD_SIZE-1:0] addr_i,
  input  logic [WORD_SIZE-1:0] store_data_i,
  input  logic [2:0]           funct3_i,
  input  logic                 is_store_i,
  output logic                 resp_valid_o,
  output logic [WORD_SIZE-1:0] resp_data_o,
  output logic [1:0]           resp_err_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [WORD_SIZE-1:0] mem_addr_o,
  output logic [3:0]           mem_be_o,
  output logic [WORD_SIZE-1:0] mem_wdata_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [WORD_SIZE-1:0] mem_rdata_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t           state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [1:0]           offset_q;
  logic [2:0]           funct3_q;
  logic                 is_store_q;
  logic                 mem_req_q, mem_we_q, resp_valid_q;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_wdata_q, resp_data_q;
  logic [3:0]           mem_be_q;
  logic [1:0]           resp_err_q;

  logic [1:0]           align_offset;
  logic [2:0]           align_funct3;
  logic [3:0]           align_be;
  logic [WORD_SIZE-1:0] align_wdata, align_rdata;
  logic                 timeout_hit;

  // Lane logic sees the live request while idle and the captured one afterwards.
  assign align_offset = (state_q == IDLE) ? addr_i[1:0] : offset_q;
  assign align_funct3 = (state_q == IDLE) ? funct3_i    : funct3_q;

  lsu_align #(.WORD_SIZE(WORD_SIZE)) u_align (
    .offset_i     (align_offset),
    .funct3_i     (align_funct3),
    .store_data_i (store_data_i),
    .rdata_i      (mem_rdata_i),
    .be_o         (align_be),
    .wdata_o      (align_wdata),
    .rdata_o      (align_rdata)
  );

  // Expiry fires on the TIMEOUT_CYCLES-th cycle spent in REQ/WAIT, overriding gnt/rvalid.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      offset_q     <= '0;
      funct3_q     <= '0;
      is_store_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= LSU_OK;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            offset_q   <= addr_i[1:0];
            funct3_q   <= funct3_i;
            is_store_q <= is_store_i;
            cnt_q      <= '0;
            if (!f3_legal(funct3_i, is_store_i)) begin
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= LSU_ILLEGAL;
              resp_data_q  <= '0;
            end else if (f3_misaligned(funct3_i, addr_i[1:0])) begin
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= LSU_MISALIGN;
              resp_data_q  <= '0;
            end else begin
              state_q     <= REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store_i;
              mem_addr_q  <= {addr_i[WORD_SIZE-1:2], 2'b00};
              mem_be_q    <= align_be;
              mem_wdata_q <= align_wdata;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (timeout_hit || mem_gnt_i) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
          end
          if (timeout_hit) begin
            state_q      <= DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= LSU_TIMEOUT;
            resp_data_q  <= '0;
          end else if (mem_gnt_i) begin
            if (is_store_q) begin
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= LSU_OK;
              resp_data_q  <= '0;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (timeout_hit) begin
            state_q      <= DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= LSU_TIMEOUT;
            resp_data_q  <= '0;
          end else if (mem_rvalid_i) begin
            state_q      <= DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= LSU_OK;
            resp_data_q  <= align_rdata;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          resp_data_q <= '0;
          resp_err_q  <= LSU_OK;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_be_o     = mem_be_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised scoreboard bench for load_store_unit; a second instance covers the timeout path.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        req_valid, is_store, mem_gnt, mem_rvalid;
  logic [31:0] addr, store_data, mem_rdata;
  logic [2:0]  funct3;
  logic        req_ready, resp_valid, mem_req, mem_we;
  logic [31:0] resp_data, mem_addr, mem_wdata;
  logic [1:0]  resp_err;
  logic [3:0]  mem_be;

  logic        t_req_valid, t_is_store, t_mem_gnt, t_mem_rvalid;
  logic [31:0] t_addr, t_store_data, t_mem_rdata;
  logic [2:0]  t_funct3;
  logic        t_req_ready, t_resp_valid, t_mem_req, t_mem_we;
  logic [31:0] t_resp_data, t_mem_addr, t_mem_wdata;
  logic [1:0]  t_resp_err;
  logic [3:0]  t_mem_be;

  load_store_unit dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .addr_i(addr), .store_data_i(store_data), .funct3_i(funct3), .is_store_i(is_store),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_err_o(resp_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(t_req_valid), .req_ready_o(t_req_ready),
    .addr_i(t_addr), .store_data_i(t_store_data), .funct3_i(t_funct3), .is_store_i(t_is_store),
    .resp_valid_o(t_resp_valid), .resp_data_o(t_resp_data), .resp_err_o(t_resp_err),
    .mem_req_o(t_mem_req), .mem_we_o(t_mem_we), .mem_addr_o(t_mem_addr), .mem_be_o(t_mem_be),
    .mem_wdata_o(t_mem_wdata), .mem_gnt_i(t_mem_gnt), .mem_rvalid_i(t_mem_rvalid), .mem_rdata_i(t_mem_rdata)
  );

  typedef struct { logic [31:0] data; logic [1:0] err; int cyc; } resp_t;
  typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; int hold; } beat_t;

  resp_t rq[$];
  resp_t tq[$];
  beat_t mq[$];
  int passed = 0, total = 0, cyc = 0, hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: access size in bytes, legality, lanes and extension by plain arithmetic.
  function automatic int m_size(input logic [2:0] f);
    return (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [1:0] m_err(input logic [31:0] a, input logic [2:0] f, input logic s);
    if (s ? (f > 3'd2) : (f == 3'd3 || f > 3'd5)) return 2'b10;
    if ((a % m_size(f)) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] f);
    int v;
    v = ((1 << m_size(f)) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] sd);
    logic [31:0] w;
    int n;
    n = m_size(f);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] f, input logic [31:0] rd);
    logic [63:0] v, span;
    int n;
    n    = m_size(f);
    span = 64'd1 << (8 * n);
    v    = {32'd0, rd} >> (8 * (a % 4));
    v    = v % span;
    if (!f[2] && n < 4 && v >= (span >> 1)) v = v - span;
    return v[31:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n && mem_req) begin
      if (mq.size() == 0) check("unexpected_mem_req", {31'd0, mem_req}, 32'd0);
      else begin
        check("mem_addr", mem_addr, mq[0].addr);
        check("mem_be", {28'd0, mem_be}, {28'd0, mq[0].be});
        check("mem_we", {31'd0, mem_we}, {31'd0, mq[0].we});
        if (mq[0].we) check("mem_wdata", mem_wdata, mq[0].wdata);
        hold++;
        if (mem_gnt) begin
          check("mem_req_cycles", hold, mq[0].hold);
          hold = 0;
          void'(mq.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    resp_t r;
    if (resp_valid) begin
      if (rq.size() == 0) check("unexpected_resp", {31'd0, resp_valid}, 32'd0);
      else begin
        r = rq.pop_front();
        check("resp_data", resp_data, r.data);
        check("resp_err", {30'd0, resp_err}, {30'd0, r.err});
        check("resp_cycle", cyc, r.cyc);
      end
    end
    if (t_resp_valid) begin
      if (tq.size() == 0) check("to_unexpected_resp", {31'd0, t_resp_valid}, 32'd0);
      else begin
        r = tq.pop_front();
        check("to_resp_data", t_resp_data, r.data);
        check("to_resp_err", {30'd0, t_resp_err}, {30'd0, r.err});
        check("to_resp_cycle", cyc, r.cyc);
      end
    end
  end

  task automatic wait_idle();
    int waited = 0;
    while (!req_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("idle_bound", {31'd0, waited < 50}, 32'd1);
  endtask

  // gd: REQ cycles before the gnt cycle; rd: WAIT cycles before the rvalid cycle.
  task automatic issue(input logic [31:0] a, input logic [2:0] f, input logic s,
                       input logic [31:0] sd, input int gd, input int rd, input logic [31:0] rdv);
    resp_t r;
    beat_t b;
    logic [1:0] e;
    e = m_err(a, f, s);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    r.err  = e;
    r.data = (e == 2'b00 && !s) ? m_load(a, f, rdv) : 32'd0;
    r.cyc  = cyc + ((e != 2'b00) ? 1 : s ? 2 + gd : 3 + gd + rd);
    rq.push_back(r);
    if (e == 2'b00) begin
      b.addr = a & 32'hFFFF_FFFC; b.be = m_be(a, f); b.we = s;
      b.wdata = m_wdata(f, sd); b.hold = gd + 1;
      mq.push_back(b);
    end
    req_valid = 1'b1; addr = a; funct3 = f; is_store = s; store_data = sd;
    @(posedge clk); #1;
    req_valid = 1'b0; addr = $urandom; store_data = $urandom;
    funct3 = 3'($urandom); is_store = 1'($urandom);
    if (e == 2'b00) begin
      check("req_ready_busy", {31'd0, req_ready}, 32'd0);
      repeat (gd) begin @(posedge clk); #1; end
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      if (!s) begin
        repeat (rd) begin mem_rdata = $urandom; @(posedge clk); #1; end
        mem_rvalid = 1'b1; mem_rdata = rdv;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
    end
    wait_idle();
  endtask

  // Single LW on the TIMEOUT_CYCLES=4 instance; gk/rk = cycle after accept carrying gnt/rvalid (0 = never).
  task automatic issue_to(input logic [31:0] a, input int gk, input int rk, input logic [31:0] rdv,
                          input logic [1:0] e, input int lat);
    resp_t r;
    r.err  = e;
    r.data = (e == 2'b00) ? m_load(a, 3'b010, rdv) : 32'd0;
    r.cyc  = cyc + lat;
    tq.push_back(r);
    t_req_valid = 1'b1; t_addr = a; t_funct3 = 3'b010; t_is_store = 1'b0;
    @(posedge clk); #1;
    t_req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      t_mem_gnt = (k == gk); t_mem_rvalid = (k == rk); t_mem_rdata = rdv;
      if (k == 4) check("to_mem_req_c4", {31'd0, t_mem_req}, {31'd0, (gk == 0 || gk >= 4)});
      if (k == 5) check("to_mem_req_c5", {31'd0, t_mem_req}, 32'd0);
      @(posedge clk); #1;
    end
    t_mem_gnt = 1'b0; t_mem_rvalid = 1'b0;
    check("to_ready_after", {31'd0, t_req_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 0; addr = 0; store_data = 0; funct3 = 0; is_store = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    t_req_valid = 0; t_addr = 0; t_store_data = 0; t_funct3 = 0; t_is_store = 0;
    t_mem_gnt = 0; t_mem_rvalid = 0; t_mem_rdata = 0;
    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_to_req_ready", {31'd0, t_req_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    issue(32'h100, 3'b010, 1'b0, 32'h0, 0, 0, 32'hDEADBEEF);
    issue(32'h203, 3'b000, 1'b0, 32'h0, 0, 0, 32'h80112233);
    issue(32'h203, 3'b100, 1'b0, 32'h0, 1, 2, 32'h80112233);
    issue(32'h202, 3'b101, 1'b0, 32'h0, 0, 1, 32'h80112233);
    issue(32'h302, 3'b001, 1'b1, 32'h1234ABCD, 4, 0, 32'h0);
    issue(32'h101, 3'b010, 1'b0, 32'h0, 0, 0, 32'h0);
    issue(32'h104, 3'b011, 1'b0, 32'h0, 0, 0, 32'h0);
    issue(32'h105, 3'b100, 1'b1, 32'hFF, 0, 0, 32'h0);
    issue(32'h203, 3'b001, 1'b0, 32'h0, 0, 0, 32'h0);
    issue(32'h7, 3'b000, 1'b1, 32'hA5, 0, 0, 32'h0);

    for (int i = 0; i < 60; i++)
      issue($urandom, 3'($urandom), 1'($urandom), $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom);

    // Reset while a load waits for rvalid: abandoned, late rvalid ignored.
    mq.push_back('{addr: 32'h80, be: 4'hF, we: 1'b0, wdata: 32'h0, hold: 1});
    req_valid = 1'b1; addr = 32'h80; funct3 = 3'b010; is_store = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    check("wait_ready_low", {31'd0, req_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_resp_data", resp_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    issue(32'h40, 3'b010, 1'b1, 32'h55, 0, 0, 32'h0);

    issue_to(32'h10, 4, 0, 32'h0, 2'b11, 5);
    issue_to(32'h14, 1, 0, 32'h0, 2'b11, 5);
    issue_to(32'h18, 1, 4, 32'h11223344, 2'b11, 5);
    issue_to(32'h1C, 1, 3, 32'h99887766, 2'b00, 4);
    t_mem_rvalid = 1'b1;
    @(posedge clk); #1;
    t_mem_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("resp_queue_empty", rq.size(), 32'd0);
    check("mem_queue_empty", mq.size(), 32'd0);
    check("to_queue_empty", tq.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage directly downstream of the ALU; consumes the ALU result as the effective address.
- Performs one RV32I load or store per request over a req/gnt/rvalid data-memory port.
- Handles byte/half/word lane steering, byte enables, sign/zero extension, misalignment, illegal-size and bus-timeout errors.
- Returns one result per request to writeback. Stalls upstream via Req_ready.

Parameters:
- WORD_SIZE, 32, datapath width; only 32 is supported.
- TIMEOUT_CYCLES, 255, maximum cycles spent in REQ+WAIT before aborting; 0 disables the timeout.

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Rst_n  in  1  asynchronous active-low reset
- Req_valid  in  1  request present
- Req_ready  out  1  block can accept a request (high only in IDLE)
- Addr  in  WORD_SIZE  effective byte address (ALU Out)
- Store_data  in  WORD_SIZE  rs2 value for stores
- Funct3  in  3  RV32I size/sign field
- Is_store  in  1  1=store, 0=load
- Resp_valid  out  1  one-cycle completion pulse
- Resp_data  out  WORD_SIZE  extended load data; 0 for stores and errors
- Resp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout
- Mem_req  out  1  memory request
- Mem_we  out  1  write enable
- Mem_addr  out  WORD_SIZE  word-aligned address {Addr[31:2],2'b00}
- Mem_be  out  4  byte enables
- Mem_wdata  out  WORD_SIZE  lane-replicated store data
- Mem_gnt  in  1  request accepted by memory
- Mem_rvalid  in  1  read data valid
- Mem_rdata  in  WORD_SIZE  read word

Behaviour:
- Reset (async, Rst_n=0): state IDLE, timeout counter 0. Req_ready=1. All other outputs 0. Reset mid-transaction abandons it with no Resp_valid. Mem_rvalid/Mem_gnt arriving after reset are ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: on Req_valid (Req_ready=1), capture Addr, Store_data, Funct3, Is_store.
  - Illegal funct3: 011, 110, 111 for loads; anything other than 000/001/010 for stores. Goes to DONE with err 10.
  - Misaligned: half with Addr[0]=1, or word with Addr[1:0]≠00. Goes to DONE with err 01.
  - Illegal funct3 takes priority over misaligned.
  - Otherwise go to REQ.
- REQ: Mem_req=1. Mem_addr, Mem_we, Mem_be and Mem_wdata are held stable until the cycle Mem_gnt=1.
  - On gnt, a store goes to DONE (err 00); a load goes to WAIT.
- WAIT: on Mem_rvalid, register the extracted data and go to DONE. Mem_rvalid outside WAIT is ignored.
- DONE: Resp_valid=1 for exactly one cycle, with Resp_data/Resp_err valid; then IDLE. Writeback has no backpressure.
- Minimum latency, accept to Resp_valid: store with same-cycle gnt = 2 cycles; load with gnt then rvalid next cycle = 3 cycles; error = 1 cycle.
- Timeout: the counter clears on accept and increments each cycle in REQ or WAIT. When it reaches TIMEOUT_CYCLES (nonzero), go to DONE with err 11 and drop Mem_req the same edge. Gnt or rvalid on the expiry cycle is ignored.
- Byte enables: byte = 4'b0001<<Addr[1:0]; half = 4'b0011<<Addr[1:0]; word = 4'b1111. Driven for loads as well.
- Mem_wdata: byte = {4{Store_data[7:0]}}; half = {2{Store_data[15:0]}}; word = Store_data. Mem_we = Is_store.
- Load extraction: shift Mem_rdata right by 8*Addr[1:0], then:
  - LB (000) sign-extends bit 7.
  - LH (001) sign-extends bit 15.
  - LW (010) passes through.
  - LBU (100) and LHU (101) zero-extend.
- Outputs are registered, except Req_ready, which is decoded from state.

Decomposition:
- Shared package risc_pkg holds:
  - Funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - Error code constants (LSU_OK, LSU_MISALIGN, LSU_ILLEGAL, LSU_TIMEOUT).
  - lsu_state_t enum.
- Sub-module lsu_align, purely combinational: byte enable generation, store lane replication, load extraction/extension. It is reused later by the instruction-fetch side.

Test Plan:
- LW Addr=0x100, gnt in REQ cycle, rvalid next cycle with rdata=0xDEADBEEF -> Mem_addr=0x100, Mem_be=1111, Resp_data=0xDEADBEEF, err 00, Resp_valid 3 cycles after accept.
- LB Addr=0x203, rdata=0x80112233 -> Mem_be=1000, Resp_data=0xFFFFFF80. LBU same stimulus -> 0x00000080. LHU Addr=0x202 -> 0x00008011.
- SH Addr=0x302, Store_data=0x1234ABCD, gnt delayed 5 cycles -> Mem_req held 5 cycles with Mem_be=1100, Mem_wdata=0xABCDABCD, Mem_we=1; then Resp_valid with err 00, Resp_data=0.
- LW Addr=0x101 -> no Mem_req, Resp_valid next cycle with err 01. Funct3=011 load -> err 10. SB with Funct3=100 -> err 10.
- TIMEOUT_CYCLES=4, load with gnt but no rvalid -> Resp_valid with err 11 exactly 4 cycles after entering REQ; a later stray rvalid in IDLE produces no response.
- Rst_n pulsed low while in WAIT -> outputs 0 immediately, Req_ready=1. Subsequent rvalid ignored. A new SW Addr=0x40, Store_data=0x55 then completes normally.
